uart_console_fifo: RTL and testbench

// - Consumer of the bench UART receiver byte strobe (rx_rdy/rx_err/rx_data).
// - Buffers received console bytes in a FIFO and serves them to the host side
//   (C++ wrapper or bench monitor) over a valid/ready byte stream.
// - Tracks line count, framing errors, overflow and an end-of-transmission

---
 rtl/uart_console_fifo.sv | 147 ++++++++++++++
 tb/tb_uart_console_fifo.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_console_fifo.sv
// Console byte sink for the bench UART receiver: filters and buffers received
// bytes, tracks lines/errors/overflow/EOT and serves a registered valid/ready stream.
module uart_console_fifo #(
    parameter int         DEPTH    = 16,
    parameter logic [7:0] EOT_CHAR = 8'h04,
    parameter bit         STRIP_CR = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_rdy,
    input  logic                     rx_err,
    input  logic [7:0]               rx_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic                     out_eol,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [15:0]              err_cnt,
    output logic [15:0]              line_cnt,
    output logic                     eot
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic {RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_eol_q, out_eol_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic [15:0]      line_cnt_q, line_cnt_d;
    logic             eot_q, eot_d;

    logic pop, good, is_eot, cand, push, empty_after_pop;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_eol_d   = out_eol_q;
        overflow_d  = overflow_q;
        err_cnt_d   = err_cnt_q;
        line_cnt_d  = line_cnt_q;
        eot_d       = eot_q;

        pop    = out_valid_q & out_ready;
        good   = rx_rdy & ~rx_err;
        is_eot = good && (state_q == RUN) && (rx_data == EOT_CHAR);
        cand   = good && (state_q == RUN) && !is_eot &&
                 !(STRIP_CR && (rx_data == 8'h0D));
        // A full FIFO still takes a byte when the head leaves in the same cycle.
        push   = cand && ((count_q < CNT_FULL) || pop);
        empty_after_pop = pop ? (count_q == CNT_ONE) : (count_q == '0);

        if (rx_rdy && rx_err && (err_cnt_q != 16'hFFFF))
            err_cnt_d = err_cnt_q + 16'd1;

        if (is_eot) begin
            state_d = DONE;
            eot_d   = 1'b1;
        end

        if (cand && !push)
            overflow_d = 1'b1;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rx_data == 8'h0A)
                line_cnt_d = line_cnt_q + 16'd1;
        end

        if (pop)
            rd_ptr_d = rd_ptr_q + PTR_ONE;

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Head register is reloaded from the next read pointer, or straight
        // from rx_data when the pushed byte lands in an otherwise empty FIFO.
        out_valid_d = (count_d != '0);
        if (push && empty_after_pop)
            out_data_d = rx_data;
        else if (count_d != '0)
            out_data_d = mem_q[rd_ptr_d];
        out_eol_d = out_valid_d && (out_data_d == 8'h0A);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_eol_q   <= 1'b0;
            overflow_q  <= 1'b0;
            err_cnt_q   <= 16'h0000;
            line_cnt_q  <= 16'h0000;
            eot_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_eol_q   <= out_eol_d;
            overflow_q  <= overflow_d;
            err_cnt_q   <= err_cnt_d;
            line_cnt_q  <= line_cnt_d;
            eot_q       <= eot_d;
        end
    end

    // Storage is data only; validity is carried entirely by the pointers/count.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= rx_data;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_eol   = out_eol_q;
    assign level     = count_q;
    assign overflow  = overflow_q;
    assign err_cnt   = err_cnt_q;
    assign line_cnt  = line_cnt_q;
    assign eot       = eot_q;

endmodule

// File: tb/tb_uart_console_fifo.sv
// Self-checking bench for uart_console_fifo: vector table plus scoreboarded
// corner-case sequences (overflow, full with pop, EOT/reset, error saturation).
module tb_uart_console_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_rdy = 1'b0;
    logic        rx_err = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_eol;
    logic [4:0]  level;
    logic        overflow;
    logic [15:0] err_cnt;
    logic [15:0] line_cnt;
    logic        eot;

    uart_console_fifo #(.DEPTH(16), .EOT_CHAR(8'h04), .STRIP_CR(1'b1)) dut (
        .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_err(rx_err), .rx_data(rx_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_eol(out_eol), .level(level), .overflow(overflow), .err_cnt(err_cnt),
        .line_cnt(line_cnt), .eot(eot)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] sb[$];
    int m_level = 0;
    int m_err = 0;
    int m_line = 0;
    bit m_eot = 1'b0;
    bit m_ovf = 1'b0;

    typedef struct {
        bit       rdy;
        bit       err;
        bit [7:0] data;
        bit       ready;
        int       exp_level;
        bit       exp_valid;
        bit [7:0] exp_head;
        bit       exp_eol;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: score the pop seen before the edge, update the model, then
    // compare all counters/flags shortly after the edge.
    task automatic step();
        logic       pop_s;
        logic [7:0] e;
        pop_s = out_valid && out_ready;
        if (pop_s) begin
            if (sb.size() == 0) begin
                check("pop_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                check("pop_data", out_data, e);
                check("pop_eol", out_eol, (e == 8'h0A));
            end
        end
        if (rx_rdy && rx_err && m_err < 65535) m_err++;
        if (rx_rdy && !rx_err && !m_eot) begin
            if (rx_data == 8'h04) m_eot = 1'b1;
            else if (rx_data != 8'h0D) begin
                if (m_level < 16 || pop_s) begin
                    sb.push_back(rx_data);
                    m_level++;
                    if (rx_data == 8'h0A) m_line = (m_line + 1) & 16'hFFFF;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        if (pop_s) m_level--;
        @(posedge clk);
        #1;
        check("level", level, m_level);
        check("out_valid", out_valid, (m_level != 0));
        check("overflow", overflow, m_ovf);
        check("err_cnt", err_cnt, m_err);
        check("line_cnt", line_cnt, m_line);
        check("eot", eot, m_eot);
    endtask

    task automatic drive(input bit r, input bit e, input logic [7:0] d, input bit rd);
        rx_rdy = r;
        rx_err = e;
        rx_data = d;
        out_ready = rd;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_rdy = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        m_level = 0; m_err = 0; m_line = 0; m_eot = 1'b0; m_ovf = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_line_cnt", line_cnt, 0);
        check("rst_eot", eot, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_eol", out_eol, 0);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1, 0, 8'h4F, 1, 1, 1, 8'h4F, 0};
        vecs[1] = '{1, 0, 8'h4B, 1, 1, 1, 8'h4B, 0};
        vecs[2] = '{1, 0, 8'h0A, 1, 1, 1, 8'h0A, 1};
        vecs[3] = '{0, 0, 8'h00, 1, 0, 0, 8'h00, 0};
        vecs[4] = '{1, 0, 8'h0D, 1, 0, 0, 8'h00, 0};
        vecs[5] = '{1, 0, 8'h0A, 1, 1, 1, 8'h0A, 1};
        vecs[6] = '{0, 0, 8'h00, 1, 0, 0, 8'h00, 0};
        vecs[7] = '{1, 1, 8'h41, 1, 0, 0, 8'h00, 0};

        do_reset();

        // "OK\n", then CR stripping, then a framing error, all with out_ready=1
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].rdy, vecs[i].err, vecs[i].data, vecs[i].ready);
            check("vec_level", level, vecs[i].exp_level);
            check("vec_valid", out_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                check("vec_head", out_data, vecs[i].exp_head);
                check("vec_eol", out_eol, vecs[i].exp_eol);
            end
        end
        check("ok_line_cnt", line_cnt, 2);
        check("ok_err_cnt", err_cnt, 1);

        // Overflow: 17 bytes into a stalled 16-entry FIFO (non-control byte values)
        do_reset();
        for (int i = 0; i < 17; i++) drive(1, 0, 8'(8'h40 + i), 0);
        check("ovf_level", level, 16);
        check("ovf_flag", overflow, 1);
        check("ovf_hold_head", out_data, 8'h40);
        for (int i = 0; i < 18; i++) drive(0, 0, 8'h00, 1);
        check("ovf_drained", sb.size(), 0);
        check("ovf_sticky", overflow, 1);

        // Full FIFO with push and pop in the same cycle
        do_reset();
        for (int i = 0; i < 16; i++) drive(1, 0, 8'(8'h20 + i), 0);
        drive(1, 0, 8'h30, 1);
        check("fullpop_level", level, 16);
        check("fullpop_ovf", overflow, 0);
        check("fullpop_head", out_data, 8'h21);
        for (int i = 0; i < 17; i++) drive(0, 0, 8'h00, 1);
        check("fullpop_drained", sb.size(), 0);

        // EOT terminates the stream; reset brings it back
        do_reset();
        drive(1, 0, 8'h41, 1);
        drive(1, 1, 8'h55, 1);
        drive(1, 0, 8'h04, 1);
        drive(1, 0, 8'h42, 1);
        drive(1, 0, 8'h04, 1);
        drive(0, 0, 8'h00, 1);
        check("eot_flag", eot, 1);
        check("eot_err_cnt", err_cnt, 1);
        check("eot_level", level, 0);
        do_reset();
        drive(1, 0, 8'h42, 1);
        check("post_rst_head", out_data, 8'h42);
        drive(0, 0, 8'h00, 1);
        check("post_rst_drained", sb.size(), 0);

        // Error counter saturation
        do_reset();
        for (int i = 0; i < 65540; i++) drive(1, 1, 8'h00, 1);
        check("err_sat", err_cnt, 16'hFFFF);
        drive(0, 0, 8'h00, 1);
        check("err_sat_hold", err_cnt, 16'hFFFF);
        check("final_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
